// File: rtl/cim_bank_loader.sv
// cim_bank_loader: clocked CIM weight bank. ROWS rows of paired WW-bit
// weights (A/B) drive the compute array in parallel. A start/length command
// followed by a valid/ready beat stream writes consecutive rows from a base
// row. The row pointer wraps past the last row. Status outputs are busy,
// a one-cycle done pulse, and a sticky written flag per row.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   cfg_start/base/len        command strobe (sampled in IDLE only), first row,
//                             row count (0..ROWS, larger values clamp to ROWS)
//   in_valid/in_ready/in_data beat stream, in_data = {A, B}
//   busy, done                LOAD state, 1-cycle completion pulse
//   row_written               sticky per-row write flag
//   wb_a, wb_b                row r weights at [r*WW +: WW]
//
// Optional feature macro CIM_BANK_LOADER_READBACK_EN adds the ports
//   rd_en, rd_addr, rd_data, rd_valid, which give a registered row readback.
//   A read in the same cycle as a write to that row returns the old value.

module cim_bank_row #(
  parameter int WW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [2*WW-1:0] d,
  output logic [WW-1:0] a,
  output logic [WW-1:0] b,
  output logic          written
);
  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      written <= 1'b0;
    end else if (we) begin
      a       <= d[2*WW-1:WW];
      b       <= d[WW-1:0];
      written <= 1'b1;
    end
  end
endmodule

module cim_bank_loader #(
  parameter int  ROWS   = 8,
  parameter int  WW     = 12,
  localparam int ADDR_W = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic [ADDR_W:0]      cfg_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WW-1:0]      in_data,
  output logic                 busy,
  output logic                 done,
  output logic [ROWS-1:0]      row_written,
  output logic [ROWS*WW-1:0]   wb_a,
  output logic [ROWS*WW-1:0]   wb_b
`ifdef CIM_BANK_LOADER_READBACK_EN
  ,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [2*WW-1:0]      rd_data,
  output logic                 rd_valid
`endif
);
  localparam logic [ADDR_W:0]   ROWS_L = (ADDR_W+1)'(ROWS);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(ROWS-1);
  localparam logic [ADDR_W:0]   ONE    = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W:0]     cnt;
  logic                acc;
  logic                latch;
  logic [ADDR_W-1:0]   base_mod;
  logic [ADDR_W:0]     len_clamp;
  logic [ROWS-1:0]     we;

  assign acc       = in_valid && in_ready;
  assign latch     = (state == S_IDLE) && cfg_start && (cfg_len != '0);
  // Base reduced modulo ROWS so a non-power-of-two bank never points past the end.
  assign base_mod  = ADDR_W'(32'(cfg_base) % ROWS);
  // Clamp keeps each row written at most once per command.
  assign len_clamp = (cfg_len > ROWS_L) ? ROWS_L : cfg_len;

  // Outputs come from state alone: no in_valid -> in_ready path.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (cfg_start) state_nx = (cfg_len == '0) ? S_DONE : S_LOAD;
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && cnt == ONE) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (latch) begin
        ptr <= base_mod;
        cnt <= len_clamp;
      end else if (acc) begin
        ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        cnt <= cnt - ONE;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign we[r] = acc && (ptr == ADDR_W'(r));
    cim_bank_row #(.WW(WW)) u_row (
      .clk     (clk),
      .rst     (rst),
      .we      (we[r]),
      .d       (in_data),
      .a       (wb_a[r*WW +: WW]),
      .b       (wb_b[r*WW +: WW]),
      .written (row_written[r])
    );
  end

`ifdef CIM_BANK_LOADER_READBACK_EN
  // Reads the row registers before this cycle's write lands: old value wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= {wb_a[rd_addr*WW +: WW], wb_b[rd_addr*WW +: WW]};
    end
  end
`endif
endmodule
